mips_load_store_unit: RTL and testbench
=======================================

Name: mips_load_store_unit

Overview:
- Sits between the MIPS datapath's memory stage and the byte-addressed, big-endian `mips_memory` block, which has a registered one-cycle read.
- Accepts one load/store request at a time, word-aligns the address, and generates byte enables and lane-replicated store data.
- Extracts, sign/zero-extends or merges load data, including LWL/LWR partial-word merges.
- Flags misaligned or illegal requests without touching memory.

Parameters:
- ADDR_W, 32, width of request and memory address.
- DATA_W, 32, data width; fixed at 32, anything else is unsupported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present; accepted on a rising edge when req_ready=1.
- req_ready  output  1  high only in IDLE.
- req_op  input  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; any other code is illegal.
- req_addr  input  32  byte address.
- req_store_data  input  32  rt value for stores.
- req_rt_old  input  32  current rt, used for the LWL/LWR merge.
- resp_valid  output  1  one-cycle response pulse.
- resp_err  output  1  valid with resp_valid; misaligned or illegal op.
- resp_load_data  output  32  load result; held until the next response.
- mem_active  output  1  high in ISSUE.
- mem_address  output  32  {req_addr[31:2],2'b00}.
- mem_read_en  output  1  load strobe.
- mem_wr_en  output  1  store strobe.
- mem_byte_en  output  4  bit i enables lane data[8i+7:8i]; lane 3 = byte offset 0 (big-endian).
- mem_data_out  output  32  store data to memory data_in.
- mem_data_in  input  32  memory data_out, valid the cycle after mem_read_en.

Behaviour:
- Reset values: state IDLE. resp_valid, resp_err, resp_load_data, mem_active, mem_read_en, mem_wr_en, mem_byte_en, mem_data_out and mem_address are all 0.
- Reset in any state aborts the operation. Strobes are low from the next cycle, no response is issued, and req_ready=1 after reset deasserts.
- All mem_* outputs and resp_* outputs are registered. Strobes are high for exactly one cycle per access.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE, req_valid=1:
  - Latch op, addr, store_data and rt_old; k = addr[1:0].
  - Illegal op, or misaligned access (LH/LHU/SH with k[0]=1; LW/SW with k!=0): go to RESP with resp_err=1. No strobes are driven.
  - Otherwise go to ISSUE.
- ISSUE:
  - Drive mem_active=1, mem_address, and mem_read_en (load) or mem_wr_en (store).
  - Loads go to CAPTURE; stores go to RESP.
- CAPTURE: compute the result from mem_data_in, W = word, byte k = W[31-8k -: 8].
  - LB/LBU: sign/zero-extend byte k.
  - LH/LHU: sign/zero-extend halfword W[31-8k -: 16].
  - LW: W.
  - LWL: (W << 8k) | (rt_old & ((1<<8k)-1)).
  - LWR: (W >> 8(3-k)) | (rt_old & ~(32'hFFFFFFFF >> 8(3-k))).
  - Register the result and go to RESP.
- RESP:
  - resp_valid=1 for one cycle.
  - resp_err=1 only for rejected requests.
  - resp_load_data is unchanged for stores and errors.
  - Next state is IDLE; a new request can be accepted the following cycle.
- Store lanes:
  - SB: mem_byte_en = 1<<(3-k), data = {4{sd[7:0]}}.
  - SH: k=0 gives 4'b1100, k=2 gives 4'b0011; data = {2{sd[15:0]}}.
  - SW: 4'b1111, data = sd.
- Latency from the accept edge to resp_valid: load 3 cycles, store 2, error 1.
- req_valid outside IDLE is ignored; the request is not queued.
- mem_read_en and mem_wr_en are never high together.

Test Plan:
- LW at 0x10, memory word 0x8badf00d → one mem_read_en pulse with mem_address=0x10; resp_load_data=0x8badf00d, resp_err=0, resp_valid 3 cycles after accept.
- LB at 0x13 and LBU at 0x13, word 0x123456F0 → LB gives 0xFFFFFFF0, LBU gives 0x000000F0. LH at 0x12 gives 0x000056F0.
- LWL at 0x21, word 0xAABBCCDD, rt_old 0x11223344 → 0xBBCCDD44. LWR at 0x21 with the same inputs → 0x1122AABB.
- SB at 0x32 with sd 0x000000A5 → mem_byte_en=4'b0010, mem_data_out=0xA5A5A5A5. SH at 0x30 → 4'b1100. SW → 4'b1111; resp_valid 2 cycles after accept.
- LW at 0x41, SH at 0x43, and op 7 → resp_err=1 with resp_valid the cycle after accept; mem_read_en and mem_wr_en stay 0.
- Reset asserted in CAPTURE → no resp_valid; all outputs 0 the next cycle; req_ready=1 once reset is released; a back-to-back LW afterwards completes normally.

Source files
------------

// File: rtl/mips_load_store_unit.sv
`default_nettype none
// ============================================================================
// mips_load_store_unit: one-at-a-time MIPS load/store sequencer for a
// big-endian, word-wide memory with a registered one-cycle read.
// Revision: 1.0
// ============================================================================
module mips_load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_store_data_i,
  input  logic [DATA_W-1:0] req_rt_old_i,
  output logic              resp_valid_o,
  output logic              resp_err_o,
  output logic [DATA_W-1:0] resp_load_data_o,
  output logic              mem_active_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_read_en_o,
  output logic              mem_wr_en_o,
  output logic [3:0]        mem_byte_en_o,
  output logic [DATA_W-1:0] mem_data_out_o,
  input  logic [DATA_W-1:0] mem_data_in_i
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  logic [1:0]        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        k_q, k_d;
  logic [DATA_W-1:0] rt_q, rt_d;

  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_load_data_q, resp_load_data_d;
  logic              mem_active_q, mem_active_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              mem_read_en_q, mem_read_en_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [3:0]        mem_byte_en_q, mem_byte_en_d;
  logic [DATA_W-1:0] mem_data_out_q, mem_data_out_d;

  logic              w_accept;
  logic              w_req_load;
  logic              w_req_store;
  logic              w_req_bad;
  logic [4:0]        w_sh;
  logic [4:0]        w_rsh;
  logic [31:0]       w_byte_sh;
  logic [31:0]       w_half_sh;
  logic [31:0]       w_load_res;

  assign req_ready_o = (state_q == S_IDLE);
  assign w_accept    = (state_q == S_IDLE) && req_valid_i;
  assign w_req_load  = (req_op_i <= OP_LWR);
  assign w_req_store = (req_op_i == OP_SB) || (req_op_i == OP_SH) || (req_op_i == OP_SW);

  always_comb begin
    w_req_bad = 1'b0;
    if (!w_req_load && !w_req_store) begin
      w_req_bad = 1'b1;
    end else if ((req_op_i == OP_LH || req_op_i == OP_LHU || req_op_i == OP_SH) && req_addr_i[0]) begin
      w_req_bad = 1'b1;
    end else if ((req_op_i == OP_LW || req_op_i == OP_SW) && (req_addr_i[1:0] != 2'b00)) begin
      w_req_bad = 1'b1;
    end
  end

  // State and all registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= S_IDLE;
      op_q             <= 4'd0;
      k_q              <= 2'd0;
      rt_q             <= '0;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_load_data_q <= '0;
      mem_active_q     <= 1'b0;
      mem_address_q    <= '0;
      mem_read_en_q    <= 1'b0;
      mem_wr_en_q      <= 1'b0;
      mem_byte_en_q    <= 4'd0;
      mem_data_out_q   <= '0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      k_q              <= k_d;
      rt_q             <= rt_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      resp_load_data_q <= resp_load_data_d;
      mem_active_q     <= mem_active_d;
      mem_address_q    <= mem_address_d;
      mem_read_en_q    <= mem_read_en_d;
      mem_wr_en_q      <= mem_wr_en_d;
      mem_byte_en_q    <= mem_byte_en_d;
      mem_data_out_q   <= mem_data_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    k_d     = k_q;
    rt_d    = rt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          k_d     = req_addr_i[1:0];
          rt_d    = req_rt_old_i;
          state_d = w_req_bad ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE:   state_d = (op_q <= OP_LWR) ? S_CAPTURE : S_RESP;
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Lane extraction: byte k of a big-endian word sits at W[31-8k -: 8]
  always_comb begin
    w_sh      = {k_q, 3'b000};
    w_rsh     = {2'd3 - k_q, 3'b000};
    w_byte_sh = mem_data_in_i >> (5'd24 - w_sh);
    w_half_sh = mem_data_in_i >> (5'd16 - w_sh);
    case (op_q)
      OP_LB:   w_load_res = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
      OP_LBU:  w_load_res = {24'd0, w_byte_sh[7:0]};
      OP_LH:   w_load_res = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
      OP_LHU:  w_load_res = {16'd0, w_half_sh[15:0]};
      OP_LWL:  w_load_res = (mem_data_in_i << w_sh) | (rt_q & ((32'd1 << w_sh) - 32'd1));
      OP_LWR:  w_load_res = (mem_data_in_i >> w_rsh) | (rt_q & ~(32'hFFFF_FFFF >> w_rsh));
      default: w_load_res = mem_data_in_i;
    endcase
  end

  // Registered outputs are decoded from the state being entered
  always_comb begin
    mem_active_d     = (state_d == S_ISSUE);
    mem_read_en_d    = (state_d == S_ISSUE) && (op_d <= OP_LWR);
    mem_wr_en_d      = (state_d == S_ISSUE) && (op_d >= OP_SB);
    mem_address_d    = mem_address_q;
    mem_byte_en_d    = 4'd0;
    mem_data_out_d   = '0;
    resp_valid_d     = (state_d == S_RESP);
    resp_err_d       = w_accept && w_req_bad;
    resp_load_data_d = resp_load_data_q;

    if (w_accept && !w_req_bad) begin
      mem_address_d = {req_addr_i[ADDR_W-1:2], 2'b00};
      case (req_op_i)
        OP_SB: begin
          mem_byte_en_d  = 4'b1000 >> req_addr_i[1:0];
          mem_data_out_d = {4{req_store_data_i[7:0]}};
        end
        OP_SH: begin
          mem_byte_en_d  = req_addr_i[1] ? 4'b0011 : 4'b1100;
          mem_data_out_d = {2{req_store_data_i[15:0]}};
        end
        OP_SW: begin
          mem_byte_en_d  = 4'b1111;
          mem_data_out_d = req_store_data_i;
        end
        default: begin
          mem_byte_en_d  = 4'd0;
          mem_data_out_d = '0;
        end
      endcase
    end

    if (state_q == S_CAPTURE) begin
      resp_load_data_d = w_load_res;
    end
  end

  assign resp_valid_o     = resp_valid_q;
  assign resp_err_o       = resp_err_q;
  assign resp_load_data_o = resp_load_data_q;
  assign mem_active_o     = mem_active_q;
  assign mem_address_o    = mem_address_q;
  assign mem_read_en_o    = mem_read_en_q;
  assign mem_wr_en_o      = mem_wr_en_q;
  assign mem_byte_en_o    = mem_byte_en_q;
  assign mem_data_out_o   = mem_data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_mips_load_store_unit: table-driven bench with a response scoreboard.
// Revision: 1.0
// ============================================================================
module tb_mips_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_store_data;
  logic [31:0] req_rt_old;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_load_data;
  logic        mem_active;
  logic [31:0] mem_address;
  logic        mem_read_en;
  logic        mem_wr_en;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in = 32'd0;

  mips_load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_op_i         (req_op),
    .req_addr_i       (req_addr),
    .req_store_data_i (req_store_data),
    .req_rt_old_i     (req_rt_old),
    .resp_valid_o     (resp_valid),
    .resp_err_o       (resp_err),
    .resp_load_data_o (resp_load_data),
    .mem_active_o     (mem_active),
    .mem_address_o    (mem_address),
    .mem_read_en_o    (mem_read_en),
    .mem_wr_en_o      (mem_wr_en),
    .mem_byte_en_o    (mem_byte_en),
    .mem_data_out_o   (mem_data_out),
    .mem_data_in_i    (mem_data_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-only memory model with a registered one-cycle read
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (mem_read_en) mem_data_in <= mem[mem_address[7:2]];
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rt;
    logic [31:0] word;
    logic [31:0] exp_data;
    logic        err;
    logic [3:0]  be;
    logic [31:0] dout;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          start;
    int          rd0;
    int          wr0;
    int          n_rd;
    int          n_wr;
    logic [3:0]  be;
    logic [31:0] dout;
    logic [31:0] maddr;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          rd_total = 0;
  int          wr_total = 0;
  logic [31:0] last_addr = 32'd0;
  logic [3:0]  last_be = 4'd0;
  logic [31:0] last_dout = 32'd0;
  logic [31:0] model_last = 32'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                              input logic [31:0] rt, input logic [31:0] word, input logic [31:0] exp_data,
                              input logic err, input logic [3:0] be, input logic [31:0] dout);
    vec_t v;
    v.op = op; v.addr = addr; v.sd = sd; v.rt = rt; v.word = word;
    v.exp_data = exp_data; v.err = err; v.be = be; v.dout = dout;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, 32'({resp_valid, resp_err, mem_active, mem_read_en, mem_wr_en, mem_byte_en}), 32'd0);
    check({tag, "_rdata"}, resp_load_data, 32'd0);
    check({tag, "_dout"}, mem_data_out, 32'd0);
    check({tag, "_addr"}, mem_address, 32'd0);
  endtask

  // Drive one request; hold keeps req_valid high for extra cycles with a decoy op
  task automatic send(input vec_t v, input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", 32'(req_ready), 32'd1);
    if (v.op < 4'd8 && !v.err) mem[v.addr[7:2]] = v.word;
    e.err   = v.err;
    e.start = cyc;
    e.rd0   = rd_total;
    e.wr0   = wr_total;
    e.be    = v.be;
    e.dout  = v.dout;
    e.maddr = {v.addr[31:2], 2'b00};
    if (v.err) begin
      e.lat = 1; e.n_rd = 0; e.n_wr = 0; e.data = model_last;
    end else if (v.op < 4'd8) begin
      e.lat = 3; e.n_rd = 1; e.n_wr = 0; e.data = v.exp_data; model_last = v.exp_data;
    end else begin
      e.lat = 2; e.n_rd = 0; e.n_wr = 1; e.data = model_last;
    end
    sb_q.push_back(e);
    req_valid      = 1'b1;
    req_op         = v.op;
    req_addr       = v.addr;
    req_store_data = v.sd;
    req_rt_old     = v.rt;
    @(negedge clk);
    if (hold > 0) begin
      req_op   = 4'd8;
      req_addr = 32'h3C;
      repeat (hold) @(negedge clk);
    end
    req_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("resp_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_read_en || mem_wr_en) begin
        check("active_with_strobe", 32'(mem_active), 32'd1);
        last_addr = mem_address;
      end
      if (mem_read_en && mem_wr_en) check("rd_wr_overlap", 32'd1, 32'd0);
      if (mem_read_en) rd_total++;
      if (mem_wr_en) begin
        wr_total++;
        last_be   = mem_byte_en;
        last_dout = mem_data_out;
      end
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("resp_err", 32'(resp_err), 32'(e.err));
          check("resp_data", resp_load_data, e.data);
          check("latency", 32'(cyc - e.start), 32'(e.lat));
          check("rd_pulses", 32'(rd_total - e.rd0), 32'(e.n_rd));
          check("wr_pulses", 32'(wr_total - e.wr0), 32'(e.n_wr));
          if (e.n_rd + e.n_wr > 0) check("mem_address", last_addr, e.maddr);
          if (e.n_wr > 0) begin
            check("byte_en", 32'(last_be), 32'(e.be));
            check("data_out", last_dout, e.dout);
          end
        end
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_op         = 4'd0;
    req_addr       = 32'd0;
    req_store_data = 32'd0;
    req_rt_old     = 32'd0;

    //              op     addr    sd            rt            word          exp_data      err   be       dout
    vecs.push_back(mk(4'd4, 32'h10, 32'h0,        32'h0,        32'h8badf00d, 32'h8badf00d, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd0, 32'h13, 32'h0,        32'h0,        32'h123456F0, 32'hFFFFFFF0, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd1, 32'h13, 32'h0,        32'h0,        32'h123456F0, 32'h000000F0, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd2, 32'h12, 32'h0,        32'h0,        32'h123456F0, 32'h000056F0, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd0, 32'h10, 32'h0,        32'h0,        32'h8badf00d, 32'hFFFFFF8B, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd0, 32'h11, 32'h0,        32'h0,        32'h8badf00d, 32'hFFFFFFAD, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd1, 32'h12, 32'h0,        32'h0,        32'h8badf00d, 32'h000000F0, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd2, 32'h10, 32'h0,        32'h0,        32'h8badf00d, 32'hFFFF8BAD, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd3, 32'h10, 32'h0,        32'h0,        32'h8badf00d, 32'h00008BAD, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd5, 32'h21, 32'h0,        32'h11223344, 32'hAABBCCDD, 32'hBBCCDD44, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd6, 32'h21, 32'h0,        32'h11223344, 32'hAABBCCDD, 32'h1122AABB, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd5, 32'h20, 32'h0,        32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd5, 32'h23, 32'h0,        32'h11223344, 32'hAABBCCDD, 32'hDD223344, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd6, 32'h20, 32'h0,        32'h11223344, 32'hAABBCCDD, 32'h112233AA, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd6, 32'h23, 32'h0,        32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD, 1'b0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd8, 32'h32, 32'h000000A5, 32'h0,        32'h0,        32'h0,        1'b0, 4'b0010, 32'hA5A5A5A5));
    vecs.push_back(mk(4'd8, 32'h31, 32'h12345677, 32'h0,        32'h0,        32'h0,        1'b0, 4'b0100, 32'h77777777));
    vecs.push_back(mk(4'd9, 32'h30, 32'h0000BEEF, 32'h0,        32'h0,        32'h0,        1'b0, 4'b1100, 32'hBEEFBEEF));
    vecs.push_back(mk(4'd9, 32'h32, 32'hABCD1234, 32'h0,        32'h0,        32'h0,        1'b0, 4'b0011, 32'h12341234));
    vecs.push_back(mk(4'd10,32'h34, 32'hCAFEF00D, 32'h0,        32'h0,        32'h0,        1'b0, 4'b1111, 32'hCAFEF00D));
    vecs.push_back(mk(4'd4, 32'h41, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd9, 32'h43, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd7, 32'h40, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd4, 32'h42, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd10,32'h46, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd2, 32'h11, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd15,32'h00, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd11,32'h04, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 4'b0000, 32'h0));

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    check_idle_outputs("post_reset");

    foreach (vecs[i]) send(vecs[i], 0);

    // req_valid held through ISSUE/CAPTURE must not start a second access
    send(mk(4'd4, 32'h10, 32'h0, 32'h0, 32'h8badf00d, 32'h8badf00d, 1'b0, 4'b0000, 32'h0), 2);

    // Reset while in CAPTURE aborts the load without a response
    mem[20] = 32'h13572468;
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'd4;
    req_addr  = 32'h50;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    reset = 1'b0;
    model_last = 32'd0;
    check("ready_after_abort", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    send(mk(4'd4, 32'h50, 32'h0, 32'h0, 32'h13572468, 32'h13572468, 1'b0, 4'b0000, 32'h0), 0);
    send(mk(4'd10, 32'h54, 32'h0BADCAFE, 32'h0, 32'h0, 32'h0, 1'b0, 4'b1111, 32'h0BADCAFE), 0);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
